// File: rtl/mem_access_unit_if.sv
// Request-side and memory-side bundles for the load/store unit.
// The unit is the slave of the execute stage and the master of the memory data port.
interface lsu_req_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] rdata;

  modport master (output req, we, funct3, addr, wdata, input busy, done, fault, rdata);
  modport slave  (input req, we, funct3, addr, wdata, output busy, done, fault, rdata);
endinterface

interface mem_port_if #(parameter int LINE_BITS = 13);
  logic [LINE_BITS-1:0] mem_line;
  logic [31:0]          mem_write_data;
  logic                 mem_write;
  logic [31:0]          mem_data;

  modport master (output mem_line, mem_write_data, mem_write, input mem_data);
  modport slave  (input mem_line, mem_write_data, mem_write, output mem_data);
endinterface

// File: rtl/mem_access_unit.sv
// Byte-addressed RV32I load/store onto a word-line memory port; load/SW done 2 cycles after accept, SB/SH 3, fault 1.
// One request in flight: req is only sampled while busy is low; sub-word stores read-modify-write the line.
module mem_access_unit #(
  parameter int LINE_BITS = 13
) (
  input  logic       clk,
  input  logic       reset,
  lsu_req_if.slave   cpu,
  mem_port_if.master mem
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW, STORE, RESP} state_t;

  state_t               state, state_nxt;
  logic                 legal;
  logic [1:0]           lane;
  logic [2:0]           f3_q;
  logic [15:0]          wdata_q;
  logic [LINE_BITS-1:0] line_q;
  logic [31:0]          wr_word;
  logic [31:0]          rdata_q;
  logic                 fault_q;
  logic [31:0]          shifted;
  logic [31:0]          load_ext;
  logic [31:0]          merged;
  logic                 unused_addr_hi;

  // Address bits above the line index are dropped, so the byte space wraps.
  assign unused_addr_hi = ^cpu.addr[31:LINE_BITS+2];

  always_comb begin
    legal = 1'b0;
    if (cpu.we) begin
      case (cpu.funct3)
        3'b000:  legal = 1'b1;
        3'b001:  legal = !cpu.addr[0];
        3'b010:  legal = (cpu.addr[1:0] == 2'b00);
        default: legal = 1'b0;
      endcase
    end else begin
      case (cpu.funct3)
        3'b000, 3'b100: legal = 1'b1;
        3'b001, 3'b101: legal = !cpu.addr[0];
        3'b010:         legal = (cpu.addr[1:0] == 2'b00);
        default:        legal = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    cpu.busy           = (state != IDLE);
    cpu.done           = (state == RESP);
    cpu.fault          = (state == RESP) && fault_q;
    cpu.rdata          = rdata_q;
    mem.mem_line       = line_q;
    mem.mem_write_data = wr_word;
    mem.mem_write      = (state == STORE) && !reset;
    case (state)
      IDLE: begin
        if (cpu.req) begin
          if (!legal)                    state_nxt = RESP;
          else if (!cpu.we)              state_nxt = LOAD;
          else if (cpu.funct3 == 3'b010) state_nxt = STORE;
          else                           state_nxt = RMW;
        end
      end
      LOAD:    state_nxt = RESP;
      RMW:     state_nxt = STORE;
      STORE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Half accesses are 2-byte aligned here, so lane*8 is always 0 or 16 for them.
  always_comb begin
    shifted  = mem.mem_data >> {lane, 3'b000};
    load_ext = mem.mem_data;
    case (f3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = mem.mem_data;
    endcase
    merged = mem.mem_data;
    if (f3_q[0]) merged[{lane[1], 4'b0000} +: 16] = wdata_q;
    else         merged[{lane, 3'b000} +: 8]      = wdata_q[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane    <= 2'd0;
      f3_q    <= 3'd0;
      wdata_q <= 16'd0;
      line_q  <= '0;
      wr_word <= 32'd0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu.req) begin
            lane    <= cpu.addr[1:0];
            f3_q    <= cpu.funct3;
            wdata_q <= cpu.wdata[15:0];
            line_q  <= cpu.addr[LINE_BITS+1:2];
            fault_q <= !legal;
            if (legal && cpu.we && cpu.funct3 == 3'b010) wr_word <= cpu.wdata;
          end
        end
        LOAD:    rdata_q <= load_ext;
        RMW:     wr_word <= merged;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a request-level model predicts per-cycle outputs and memory contents.
module tb_mem_access_unit;
  localparam int LB = 13;
  localparam int NWORDS = 1 << LB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;

  lsu_req_if cpu ();
  mem_port_if #(.LINE_BITS(LB)) mp ();

  mem_access_unit #(.LINE_BITS(LB)) dut (.clk(clk), .reset(reset), .cpu(cpu), .mem(mp));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem_arr [0:NWORDS-1];
  logic [31:0] ref_mem [0:NWORDS-1];
  assign mp.mem_data = mem_arr[mp.mem_line];
  always @(posedge clk) begin
    if (mp.mem_write) begin
      mem_arr[mp.mem_line] <= mp.mem_write_data;
      wr_count <= wr_count + 1;
    end
  end

  // Expectations for the request currently in flight.
  bit          chk_en = 1'b0;
  bit          m_active = 1'b0;
  int          e_cyc = 0;
  int          m_lat = 0;
  bit          m_fault = 1'b0;
  bit          m_store = 1'b0;
  bit          m_rmw = 1'b0;
  int          m_line = 0;
  logic [31:0] m_wword = '0;
  logic [31:0] m_rd_old = '0;
  logic [31:0] m_rd_new = '0;
  int          m_rd_upd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_legal(input bit w, input int f3, input int a);
    int al;
    al = a % 4;
    if (w && !(f3 inside {0, 1, 2})) return 0;
    if (!w && !(f3 inside {0, 1, 2, 4, 5})) return 0;
    if ((f3 == 1 || f3 == 5) && (al % 2) != 0) return 0;
    if (f3 == 2 && al != 0) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input int a, input int f3);
    int unsigned w, b, h;
    int v;
    w = word;
    b = (w >> (8 * (a % 4))) % 256;
    h = (w >> (8 * (a % 4))) % 65536;
    case (f3)
      0: begin v = b; if (v > 127) v = v - 256; return v; end
      1: begin v = h; if (v > 32767) v = v - 65536; return v; end
      4: return b;
      5: return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] word, input int a, input int f3,
                                              input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    sh = 8 * (a % 4);
    if (f3 == 2) return wd;
    mask = (f3 == 0) ? 32'h0000_00FF : 32'h0000_FFFF;
    return (word & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  // Per-cycle comparison against the request-level expectation.
  always @(negedge clk) begin
    int t;
    bit busy_e, done_e, wr_e;
    if (chk_en) begin
      t      = cyc - e_cyc;
      busy_e = m_active && t >= 1 && t <= m_lat;
      done_e = m_active && t == m_lat;
      wr_e   = m_active && m_store && !m_fault && t == m_lat - 1;
      chk("busy", {31'd0, cpu.busy}, {31'd0, busy_e});
      chk("done", {31'd0, cpu.done}, {31'd0, done_e});
      chk("fault", {31'd0, cpu.fault}, {31'd0, done_e && m_fault});
      chk("mem_write", {31'd0, mp.mem_write}, {31'd0, wr_e});
      chk("rdata", cpu.rdata, (cyc >= m_rd_upd) ? m_rd_new : m_rd_old);
      if (wr_e) begin
        chk("wr_line", 32'(mp.mem_line), m_line);
        chk("wr_data", mp.mem_write_data, m_wword);
      end
      if (m_active && !m_fault && t == 1 && (!m_store || m_rmw))
        chk("rd_line", 32'(mp.mem_line), m_line);
    end
  end

  task automatic do_req(input bit w, input int f3, input logic [31:0] a, input logic [31:0] wd,
                        input bit junk);
    logic [31:0] word;
    int ai;
    @(negedge clk);
    if (cyc >= m_rd_upd) m_rd_old = m_rd_new;
    ai      = int'(a % (NWORDS * 4));
    m_line  = ai / 4;
    word    = ref_mem[m_line];
    m_fault = !model_legal(w, f3, ai);
    m_store = w;
    m_rmw   = w && f3 != 2;
    m_rd_new = m_rd_old;
    if (m_fault) m_lat = 1;
    else if (!w) begin
      m_lat    = 2;
      m_rd_new = model_load(word, ai, f3);
    end else begin
      m_lat   = m_rmw ? 3 : 2;
      m_wword = model_store(word, ai, f3, wd);
      ref_mem[m_line] = m_wword;
    end
    m_rd_upd   = cyc + m_lat;
    e_cyc      = cyc;
    m_active   = 1'b1;
    cpu.req    = 1'b1;
    cpu.we     = w;
    cpu.funct3 = 3'(f3);
    cpu.addr   = a;
    cpu.wdata  = wd;
    for (int k = 1; k <= m_lat; k++) begin
      @(negedge clk);
      if (junk) begin
        cpu.req = 1'b1; cpu.we = 1'b1; cpu.funct3 = 3'b010;
        cpu.addr = 32'h0; cpu.wdata = 32'hFFFF_FFFF;
      end else cpu.req = 1'b0;
    end
    cpu.req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) begin
      mem_arr[i] = 32'(i) * 32'h0101_0101;
      ref_mem[i] = 32'(i) * 32'h0101_0101;
    end
    mem_arr[5] = 32'h8899_AABB; ref_mem[5] = 32'h8899_AABB;
    mem_arr[3] = 32'h1122_3344; ref_mem[3] = 32'h1122_3344;
    mem_arr[0] = 32'h0BAD_F00D; ref_mem[0] = 32'h0BAD_F00D;
    cpu.req = 1'b0; cpu.we = 1'b0; cpu.funct3 = 3'd0; cpu.addr = '0; cpu.wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, cpu.busy}, 32'd0);
    chk("rst_done", {31'd0, cpu.done}, 32'd0);
    chk("rst_fault", {31'd0, cpu.fault}, 32'd0);
    chk("rst_rdata", cpu.rdata, 32'd0);
    chk("rst_line", 32'(mp.mem_line), 32'd0);
    chk("rst_wdata", mp.mem_write_data, 32'd0);
    chk("rst_write", {31'd0, mp.mem_write}, 32'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    do_req(0, 0, 32'h17, 0, 0); chk("lit_lb",  cpu.rdata, 32'hFFFF_FF88);
    do_req(0, 4, 32'h16, 0, 0); chk("lit_lbu", cpu.rdata, 32'h0000_0099);
    do_req(0, 1, 32'h14, 0, 0); chk("lit_lh",  cpu.rdata, 32'hFFFF_AABB);
    do_req(0, 5, 32'h16, 0, 1); chk("lit_lhu", cpu.rdata, 32'h0000_8899);
    do_req(0, 2, 32'h14, 0, 1); chk("lit_lw",  cpu.rdata, 32'h8899_AABB);
    chk("lit_lw_fault", {31'd0, cpu.fault}, 32'd0);
    do_req(1, 0, 32'h0D, 32'hFFFF_FF55, 1);
    do_req(1, 1, 32'h0E, 32'h0000_CAFE, 0);
    @(negedge clk);
    chk("lit_sb_sh_word", mem_arr[3], 32'hCAFE_5544);
    chk("lit_word0_untouched", mem_arr[0], 32'h0BAD_F00D);

    // Reset during the STORE cycle of a SW must drop the write and the response.
    chk_en = 1'b0;
    @(negedge clk);
    cpu.req = 1'b1; cpu.we = 1'b1; cpu.funct3 = 3'b010; cpu.addr = 32'h0C; cpu.wdata = 32'h1234_5678;
    @(negedge clk);
    cpu.req = 1'b0;
    reset   = 1'b1;
    #1;
    chk("rst_store_write", {31'd0, mp.mem_write}, 32'd0);
    chk("rst_store_busy", {31'd0, cpu.busy}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_store_busy_after", {31'd0, cpu.busy}, 32'd0);
    chk("rst_store_done_after", {31'd0, cpu.done}, 32'd0);
    @(negedge clk);
    chk("rst_store_done_late", {31'd0, cpu.done}, 32'd0);
    chk("rst_store_word", mem_arr[3], 32'hCAFE_5544);
    m_active = 1'b0; m_rd_old = '0; m_rd_new = '0; m_rd_upd = 0;
    chk_en = 1'b1;

    do_req(1, 2, 32'h0C, 32'hDEAD_BEEF, 0);
    do_req(0, 2, 32'h0C, 0, 0);
    chk("lit_sw_word", mem_arr[3], 32'hDEAD_BEEF);
    do_req(0, 2, 32'h02, 0, 0);
    do_req(1, 1, 32'h01, 32'h0000_1111, 0);
    do_req(0, 3, 32'h08, 0, 0);
    do_req(1, 3, 32'h08, 32'h0000_2222, 0);
    chk("lit_fault_rdata", cpu.rdata, 32'hDEAD_BEEF);
    chk("lit_fault_word0", mem_arr[0], 32'h0BAD_F00D);
    do_req(0, 2, 32'h8000, 0, 0); chk("lit_alias_lw", cpu.rdata, 32'h0BAD_F00D);
    do_req(1, 0, 32'h8002, 32'h0000_0077, 0);
    do_req(0, 2, 32'h0, 0, 0);    chk("lit_alias_sb", cpu.rdata, 32'h0B77_F00D);
    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    chk("lit_write_count", wr_count, 32'd4);
    for (int i = 0; i < 8; i++) chk("mem_final", mem_arr[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1, "timeout");
  end
endmodule
